// File: rtl/gemm_tile_array_top_if.sv
// Command, SRAM A/B read and SRAM C write bundle of the GeMM tile engine.
// slave = engine side, master = host/SRAM side.
interface gemm_tile_array_top_if #(
    parameter int InDataWidth   = 8,
    parameter int OutDataWidth  = 32,
    parameter int TileM         = 4,
    parameter int TileN         = 4,
    parameter int AddrWidth     = 16,
    parameter int SizeAddrWidth = 8
);
    logic                                 start_i;
    logic [SizeAddrWidth-1:0]             M_tiles_i;
    logic [SizeAddrWidth-1:0]             K_size_i;
    logic [SizeAddrWidth-1:0]             N_tiles_i;
    logic                                 in_valid_i;
    logic                                 sram_rd_en_o;
    logic [AddrWidth-1:0]                 sram_a_addr_o;
    logic [AddrWidth-1:0]                 sram_b_addr_o;
    logic [TileM*InDataWidth-1:0]         sram_a_rdata_i;
    logic [TileN*InDataWidth-1:0]         sram_b_rdata_i;
    logic [AddrWidth-1:0]                 sram_c_addr_o;
    logic [TileM*TileN*OutDataWidth-1:0]  sram_c_wdata_o;
    logic                                 sram_c_we_o;
    logic                                 busy_o;
    logic                                 done_o;

    modport slave (
        input  start_i, M_tiles_i, K_size_i, N_tiles_i, in_valid_i,
        input  sram_a_rdata_i, sram_b_rdata_i,
        output sram_rd_en_o, sram_a_addr_o, sram_b_addr_o,
        output sram_c_addr_o, sram_c_wdata_o, sram_c_we_o, busy_o, done_o
    );

    modport master (
        output start_i, M_tiles_i, K_size_i, N_tiles_i, in_valid_i,
        output sram_a_rdata_i, sram_b_rdata_i,
        input  sram_rd_en_o, sram_a_addr_o, sram_b_addr_o,
        input  sram_c_addr_o, sram_c_wdata_o, sram_c_we_o, busy_o, done_o
    );
endinterface

// File: rtl/gemm_tile_array_top.sv
// Output-stationary TileM x TileN GeMM engine: one A column slice and one B row slice per read, one C tile per write.
// Latency: start -> done is M_tiles*N_tiles*K + 2 cycles; in_valid_i low stalls issue and adds exactly one cycle per stall.
// Backpressure: none on the C write side; A/B issue is gated by in_valid_i, accumulators hold across stalls.
module gemm_tile_array_top #(
    parameter int InDataWidth   = 8,
    parameter int OutDataWidth  = 32,
    parameter int TileM         = 4,
    parameter int TileN         = 4,
    parameter int AddrWidth     = 16,
    parameter int SizeAddrWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    gemm_tile_array_top_if.slave io
);
    localparam int NumPe = TileM * TileN;
    localparam int ProdW = 2 * InDataWidth;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_e;

    state_e                             state_q, state_d;
    logic [SizeAddrWidth-1:0]           m_tiles_q, m_tiles_d;
    logic [SizeAddrWidth-1:0]           k_size_q, k_size_d;
    logic [SizeAddrWidth-1:0]           n_tiles_q, n_tiles_d;
    logic [SizeAddrWidth-1:0]           mt_q, mt_d;
    logic [SizeAddrWidth-1:0]           nt_q, nt_d;
    logic [SizeAddrWidth-1:0]           k_q, k_d;
    logic                               beat_vld_q, beat_vld_d;
    logic                               beat_first_q, beat_first_d;
    logic                               beat_last_q, beat_last_d;
    logic [AddrWidth-1:0]               beat_addr_q, beat_addr_d;
    logic [NumPe-1:0][OutDataWidth-1:0] acc_q, acc_d;
    logic [NumPe-1:0][OutDataWidth-1:0] c_wdata_q, c_wdata_d;
    logic [AddrWidth-1:0]               c_addr_q, c_addr_d;
    logic                               c_we_q, c_we_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;

    logic                               rd_en;
    logic                               last_k, last_nt, last_mt;
    logic                               size_zero;
    logic [AddrWidth-1:0]               a_addr, b_addr, tile_addr;
    logic [OutDataWidth-1:0]            prod [NumPe];
    logic [OutDataWidth-1:0]            sum  [NumPe];

    assign rd_en   = (state_q == ISSUE) && io.in_valid_i;
    assign last_k  = (k_q  == k_size_q  - SizeAddrWidth'(1));
    assign last_nt = (nt_q == n_tiles_q - SizeAddrWidth'(1));
    assign last_mt = (mt_q == m_tiles_q - SizeAddrWidth'(1));
    assign size_zero = (io.M_tiles_i == '0) || (io.K_size_i == '0) || (io.N_tiles_i == '0);

    // Operands are widened before multiplying so the products wrap modulo 2^AddrWidth.
    assign a_addr    = AddrWidth'(mt_q) * AddrWidth'(k_size_q)  + AddrWidth'(k_q);
    assign b_addr    = AddrWidth'(k_q)  * AddrWidth'(n_tiles_q) + AddrWidth'(nt_q);
    assign tile_addr = AddrWidth'(mt_q) * AddrWidth'(n_tiles_q) + AddrWidth'(nt_q);

    for (genvar gi = 0; gi < TileM; gi++) begin : g_row
        for (genvar gj = 0; gj < TileN; gj++) begin : g_col
            logic signed [InDataWidth-1:0] a_el;
            logic signed [InDataWidth-1:0] b_el;
            logic signed [ProdW-1:0]       full;

            assign a_el = io.sram_a_rdata_i[gi*InDataWidth +: InDataWidth];
            assign b_el = io.sram_b_rdata_i[gj*InDataWidth +: InDataWidth];
            assign full = ProdW'(a_el) * ProdW'(b_el);
            assign prod[gi*TileN+gj] = OutDataWidth'(full);
            assign sum[gi*TileN+gj]  = acc_q[gi*TileN+gj] + prod[gi*TileN+gj];
        end
    end

    always_comb begin
        state_d      = state_q;
        m_tiles_d    = m_tiles_q;
        k_size_d     = k_size_q;
        n_tiles_d    = n_tiles_q;
        mt_d         = mt_q;
        nt_d         = nt_q;
        k_d          = k_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        beat_vld_d   = rd_en;
        beat_first_d = (k_q == '0);
        beat_last_d  = last_k;
        beat_addr_d  = tile_addr;
        acc_d        = acc_q;
        c_wdata_d    = c_wdata_q;
        c_addr_d     = c_addr_q;
        c_we_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (io.start_i) begin
                    m_tiles_d = io.M_tiles_i;
                    k_size_d  = io.K_size_i;
                    n_tiles_d = io.N_tiles_i;
                    mt_d      = '0;
                    nt_d      = '0;
                    k_d       = '0;
                    busy_d    = 1'b1;
                    if (size_zero) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (rd_en) begin
                    if (!last_k) begin
                        k_d = k_q + SizeAddrWidth'(1);
                    end else begin
                        k_d = '0;
                        if (!last_nt) begin
                            nt_d = nt_q + SizeAddrWidth'(1);
                        end else begin
                            nt_d = '0;
                            if (!last_mt) begin
                                mt_d = mt_q + SizeAddrWidth'(1);
                            end else begin
                                mt_d    = '0;
                                state_d = DRAIN;
                            end
                        end
                    end
                end
            end
            // Only the final beat is in flight here, so this lasts one cycle.
            DRAIN: begin
                if (beat_vld_q && beat_last_q) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // First-k beat overwrites, so a new tile needs no clear cycle.
        if (beat_vld_q) begin
            for (int p = 0; p < NumPe; p++) begin
                acc_d[p] = beat_first_q ? prod[p] : sum[p];
            end
            if (beat_last_q) begin
                c_we_d    = 1'b1;
                c_wdata_d = acc_d;
                c_addr_d  = beat_addr_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            m_tiles_q    <= '0;
            k_size_q     <= '0;
            n_tiles_q    <= '0;
            mt_q         <= '0;
            nt_q         <= '0;
            k_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            beat_vld_q   <= 1'b0;
            beat_first_q <= 1'b0;
            beat_last_q  <= 1'b0;
            beat_addr_q  <= '0;
            acc_q        <= '0;
            c_wdata_q    <= '0;
            c_addr_q     <= '0;
            c_we_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            m_tiles_q    <= m_tiles_d;
            k_size_q     <= k_size_d;
            n_tiles_q    <= n_tiles_d;
            mt_q         <= mt_d;
            nt_q         <= nt_d;
            k_q          <= k_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            beat_vld_q   <= beat_vld_d;
            beat_first_q <= beat_first_d;
            beat_last_q  <= beat_last_d;
            beat_addr_q  <= beat_addr_d;
            acc_q        <= acc_d;
            c_wdata_q    <= c_wdata_d;
            c_addr_q     <= c_addr_d;
            c_we_q       <= c_we_d;
        end
    end

    assign io.sram_rd_en_o   = rd_en;
    assign io.sram_a_addr_o  = a_addr;
    assign io.sram_b_addr_o  = b_addr;
    assign io.sram_c_addr_o  = c_addr_q;
    assign io.sram_c_wdata_o = c_wdata_q;
    assign io.sram_c_we_o    = c_we_q;
    assign io.busy_o         = busy_q;
    assign io.done_o         = done_q;
endmodule

// File: doc/gemm_tile_array_top.md
Name: gemm_tile_array_top

Overview:
Output-stationary GeMM accelerator with a TileM x TileN MAC array. It replaces the single-MAC datapath and computes C = A*B tile by tile. Each cycle it reads one packed TileM-element column slice of A and one packed TileN-element row slice of B, and writes one full TileM x TileN C tile per SRAM C word. The block sits between the host start/done handshake and three wide-word SRAMs, each with a 1-cycle read latency.

Parameters:
InDataWidth, 8, signed A/B element width
OutDataWidth, 32, signed accumulator/C element width
TileM, 4, PE array rows (A elements per A word)
TileN, 4, PE array columns (B elements per B word)
AddrWidth, 16, SRAM address width
SizeAddrWidth, 8, width of size/count inputs

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  start request, sampled only in IDLE
M_tiles_i  in  SizeAddrWidth  number of row tiles (M/TileM)
K_size_i  in  SizeAddrWidth  reduction length K
N_tiles_i  in  SizeAddrWidth  number of column tiles (N/TileN)
in_valid_i  in  1  SRAM A/B read grant; low stalls issue
sram_rd_en_o  out  1  A/B read strobe
sram_a_addr_o  out  AddrWidth  A word address = mt*K + k
sram_b_addr_o  out  AddrWidth  B word address = k*N_tiles + nt
sram_a_rdata_i  in  TileM*InDataWidth  element i at [i*InDataWidth +: InDataWidth]
sram_b_rdata_i  in  TileN*InDataWidth  element j at [j*InDataWidth +: InDataWidth]
sram_c_addr_o  out  AddrWidth  C word address = mt*N_tiles + nt
sram_c_wdata_o  out  TileM*TileN*OutDataWidth  element (i,j) at index i*TileN+j
sram_c_we_o  out  1  C write strobe
busy_o  out  1  operation in progress
done_o  out  1  single-cycle completion pulse

Behaviour:
- Reset (async, any time, including mid-operation): state IDLE; all counters, accumulators and outputs cleared to 0. No partial C write completes.
- States:
  - IDLE: on start_i, latch M_tiles_i/K_size_i/N_tiles_i and clear counters. Go to ISSUE, or to FINISH if any size is 0.
  - ISSUE: issue A/B reads.
  - DRAIN: wait for the final data beat and C write.
  - FINISH: assert done_o for 1 cycle, then return to IDLE.
- start_i outside IDLE is ignored. Size inputs are don't-care after latching.
- ISSUE:
  - sram_rd_en_o = in_valid_i. Addresses are combinational from counters, truncated to AddrWidth.
  - When sram_rd_en_o is high, advance the counters: k innermost, then nt, then mt.
  - After issuing the last triple (mt=M_tiles-1, nt=N_tiles-1, k=K-1), go to DRAIN.
  - When in_valid_i is low, counters hold and no beat is generated.
- Data valid: a 1-cycle delayed copy of sram_rd_en_o, with k==0 and k==K-1 tags delayed alongside it.
- On each valid beat, PE(i,j) computes prod = sext(a_i)*sext(b_j), signed full product sign-extended to OutDataWidth, wrapping modulo 2^OutDataWidth.
  - If first-k tag: acc <= prod (overwrite, no separate clear cycle).
  - Else: acc <= acc + prod.
- On a last-k beat:
  - Register sram_c_wdata_o <= final sums (acc + prod, or prod when K=1).
  - Register sram_c_addr_o <= the beat's tile address.
  - Assert sram_c_we_o for the next cycle only.
- Back-to-back tiles need no bubble: the next tile's first beat may arrive in the same cycle as the prior tile's C write.
- Stalls between beats leave accumulators untouched.
- DRAIN→FINISH on the cycle the final C write is registered. done_o is then asserted coincident with the final sram_c_we_o. busy_o deasserts the following cycle.
- busy_o is high from the cycle after start is accepted through the done_o cycle inclusive.
- Latency with no stalls: T = M_tiles*N_tiles*K.
  - start sampled at edge 0.
  - Reads issue in cycles 1..T.
  - Beats arrive in cycles 2..T+1.
  - Final write and done_o occur in cycle T+2.
- Zero-size case: done_o in cycle 1, busy_o high for cycle 1 only, no writes.
- sram_c_wdata_o and sram_c_addr_o hold their last values when sram_c_we_o is low.

Test Plan:
1. TileM=TileN=2, M_tiles=N_tiles=1, K=1, A word {3,-2}, B word {4,5} -> one write at addr 0 with C={12,15,-8,-10}; done_o in cycle 3; busy_o cycles 1-3.
2. M_tiles=2, N_tiles=2, K=3, random int8, in_valid_i always 1 -> 4 writes to addresses 0,1,2,3 in cycles 5,8,11,14; each matches the golden model; done_o in cycle 14.
3. Same as scenario 2 with in_valid_i low for 2 cycles mid-tile and on a tile boundary -> identical C data; done_o delayed by exactly 2 cycles.
4. Extremes: all A and B = -128, K=255, OutDataWidth=32 -> every C element = 4177920. Repeat with OutDataWidth=16 -> value wrapped to 16 bits (0xC000 = -16384).
5. K_size_i=0 -> done_o in cycle 1, no sram_rd_en_o, no sram_c_we_o. start_i pulsed while busy -> ignored, with only one done_o.
6. rst_ni asserted mid-ISSUE, then a new start -> all outputs 0 immediately; the new run produces correct results with no stale accumulator contribution.
